ct_spsram_param_init: RTL and testbench

//   Parametrised single-port SRAM wrapper. Successor to the fixed-geometry 512x144 L2C

---
 rtl/ct_l2c_sram_pkg.sv | 20 ++
 rtl/ct_f_spsram_generic.sv | 42 ++++
 rtl/ct_spsram_param_init.sv | 145 ++++++++++++++
 tb/tb_ct_spsram_param_init.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ct_l2c_sram_pkg.sv
// rtl/ct_l2c_sram_pkg.sv - shared types and helpers for the L2C single-port SRAM wrappers
package ct_l2c_sram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } sram_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic int slice_width(input int data_width, input int we_width);
        return data_width / we_width;
    endfunction

endpackage

// File: rtl/ct_f_spsram_generic.sv
// rtl/ct_f_spsram_generic.sv - behavioural single-port array, registered read, slice-masked write
module ct_f_spsram_generic
    import ct_l2c_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 144,
    parameter int WE_WIDTH   = 144
) (
    input  logic                  clk_i,
    input  logic                  cen_n_i,
    input  logic                  gwen_n_i,
    input  logic [WE_WIDTH-1:0]   wen_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SLICE = slice_width(DATA_WIDTH, WE_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] bit_mask;

    for (genvar i = 0; i < WE_WIDTH; i++) begin : g_mask
        assign bit_mask[i*SLICE +: SLICE] = {SLICE{~wen_n_i[i]}};
    end

    // Array has no reset; its contents are defined only by writes.
    always_ff @(posedge clk_i) begin
        if (!cen_n_i) begin
            if (!gwen_n_i) begin
                mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ct_spsram_param_init.sv
// rtl/ct_spsram_param_init.sv - parametrised L2C SRAM wrapper with init sweep and read-valid strobe
module ct_spsram_param_init
    import ct_l2c_sram_pkg::*;
#(
    parameter int                        ADDR_WIDTH = 9,
    parameter int                        DATA_WIDTH = 144,
    parameter int                        WE_WIDTH   = 144,
    parameter int                        RD_LAT     = 1,
    parameter bit                        INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  q_vld,
    output logic                  init_busy
);

    if (!rd_lat_legal(RD_LAT) || (DATA_WIDTH % WE_WIDTH) != 0) begin : g_bad_cfg
        $error("ct_spsram_param_init: illegal RD_LAT or DATA_WIDTH/WE_WIDTH combination");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic                  mem_cen_n;
    logic                  mem_gwen_n;
    logic [WE_WIDTH-1:0]   mem_wen_n;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_issue;

    logic                  rd_v1_q;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= INIT_EN ? ST_INIT : ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The sweep owns the array port; user requests are dropped until it finishes.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mem_cen_n  = 1'b1;
        mem_gwen_n = 1'b1;
        mem_wen_n  = '1;
        mem_addr   = A;
        mem_wdata  = D;
        rd_issue   = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_cen_n  = 1'b0;
                mem_gwen_n = 1'b0;
                mem_wen_n  = '0;
                mem_addr   = ptr_q;
                mem_wdata  = INIT_VAL;
                ptr_d      = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!CEN) begin
                    mem_cen_n  = 1'b0;
                    mem_gwen_n = GWEN;
                    mem_wen_n  = WEN;
                    rd_issue   = GWEN;
                end
            end
        endcase
    end

    ct_f_spsram_generic #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH)
    ) u_array (
        .clk_i    (forever_cpuclk),
        .cen_n_i  (mem_cen_n),
        .gwen_n_i (mem_gwen_n),
        .wen_n_i  (mem_wen_n),
        .addr_i   (mem_addr),
        .wdata_i  (mem_wdata),
        .rdata_o  (mem_rdata)
    );

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= rd_issue;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic                  rd_v2_q;
        logic [DATA_WIDTH-1:0] rd_d2_q;

        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                rd_v2_q <= 1'b0;
                rd_d2_q <= '0;
            end else begin
                rd_v2_q <= rd_v1_q;
                rd_d2_q <= mem_rdata;
            end
        end

        assign out_vld  = rd_v2_q;
        assign out_data = rd_d2_q;
    end else begin : g_lat1
        assign out_vld  = rd_v1_q;
        assign out_data = mem_rdata;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            hold_q <= '0;
        end else if (out_vld) begin
            hold_q <= out_data;
        end
    end

    // New data is forwarded in its valid cycle; otherwise the last read is held.
    assign Q         = out_vld ? out_data : hold_q;
    assign q_vld     = out_vld;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// tb/tb_ct_spsram_param_init.sv - randomized model-checked bench for ct_spsram_param_init
module tb_ct_spsram_param_init;

    localparam int AW    = 9;
    localparam int DW    = 144;
    localparam int WW    = 18;
    localparam int SW    = DW / WW;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] IV = {18{8'hA5}};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a;
    logic          cen;
    logic          gwen;
    logic [WW-1:0] wen;
    logic [DW-1:0] d;

    logic [DW-1:0] q_l1, q_l2;
    logic          vld_l1, vld_l2, busy_l1, busy_l2;

    always #5 clk = ~clk;

    ct_spsram_param_init #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WE_WIDTH (WW),
        .RD_LAT (1), .INIT_EN (1'b1), .INIT_VAL (IV)
    ) u_dut_l1 (
        .forever_cpuclk (clk), .cpurst_b (rst_n), .A (a), .CEN (cen), .GWEN (gwen),
        .WEN (wen), .D (d), .Q (q_l1), .q_vld (vld_l1), .init_busy (busy_l1)
    );

    ct_spsram_param_init #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WE_WIDTH (WW),
        .RD_LAT (2), .INIT_EN (1'b1), .INIT_VAL (IV)
    ) u_dut_l2 (
        .forever_cpuclk (clk), .cpurst_b (rst_n), .A (a), .CEN (cen), .GWEN (gwen),
        .WEN (wen), .D (d), .Q (q_l2), .q_vld (vld_l2), .init_busy (busy_l2)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr;
    bit            m_busy;
    bit            m_v1, m_v2;
    logic [DW-1:0] m_d1, m_d2, m_h1, m_h2;

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("init_busy_l1", DW'(busy_l1), DW'(m_busy));
        check("init_busy_l2", DW'(busy_l2), DW'(m_busy));
        check("q_vld_l1", DW'(vld_l1), DW'(m_v1));
        check("q_vld_l2", DW'(vld_l2), DW'(m_v2));
        check("Q_l1", q_l1, m_h1);
        check("Q_l2", q_l2, m_h2);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b1;
        m_v1   = 1'b0;
        m_v2   = 1'b0;
        m_h1   = '0;
        m_h2   = '0;
    endtask

    // Called from a falling edge; asserts reset asynchronously and checks outputs at once.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    task automatic step(input logic c, input logic g, input logic [WW-1:0] w,
                        input logic [AW-1:0] ad, input logic [DW-1:0] dd);
        bit            nv;
        logic [DW-1:0] nd;
        cen  = c;
        gwen = g;
        wen  = w;
        a    = ad;
        d    = dd;
        @(posedge clk);
        nv = 1'b0;
        nd = '0;
        if (m_busy) begin
            m_mem[m_ptr] = IV;
            m_ptr++;
            if (m_ptr == DEPTH) m_busy = 1'b0;
        end else if (!c) begin
            if (!g) begin
                for (int i = 0; i < WW; i++)
                    if (!w[i]) m_mem[ad][i*SW +: SW] = dd[i*SW +: SW];
            end else begin
                nv = 1'b1;
                nd = m_mem[ad];
            end
        end
        m_v2 = m_v1;
        m_d2 = m_d1;
        m_v1 = nv;
        m_d1 = nd;
        if (m_v1) m_h1 = m_d1;
        if (m_v2) m_h2 = m_d2;
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_step();
        logic          c, g;
        logic [WW-1:0] w;
        logic [AW-1:0] ad;
        c  = ($urandom_range(0, 3) == 0);
        g  = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
            0:       w = '0;
            1:       w = '1;
            default: w = WW'($urandom());
        endcase
        ad = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
        step(c, g, w, ad, rand_data());
    endtask

    task automatic idle();
        step(1'b1, 1'b1, '1, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] ad);
        step(1'b0, 1'b1, '1, ad, '0);
    endtask

    initial begin
        cen  = 1'b1;
        gwen = 1'b1;
        wen  = '1;
        a    = '0;
        d    = '0;
        @(negedge clk);
        pulse_reset();

        for (int c = 0; c < 300; c++) begin
            if (c == 100)      step(1'b0, 1'b0, '0, AW'(3), rand_data());
            else if (c == 101) rd(AW'(3));
            else               rand_step();
        end

        pulse_reset();
        for (int c = 0; c < DEPTH; c++) rand_step();

        rd(AW'(0));
        rd(AW'(DEPTH - 1));
        rd(AW'(3));
        idle();
        idle();

        step(1'b0, 1'b0, 18'h3FFFE, AW'(5), '1);
        rd(AW'(5));
        idle();
        idle();
        check("mask_write_addr5", q_l2, {IV[DW-1:8], 8'hFF});

        rd(AW'(1));
        rd(AW'(2));
        rd(AW'(3));
        idle();
        idle();
        idle();

        step(1'b0, 1'b0, '0, AW'(7), rand_data());
        rd(AW'(7));
        idle();
        idle();

        for (int c = 0; c < 2000; c++) rand_step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
